k2red_mul_front: RTL
====================

Name: k2red_mul_front

Overview:
- Upstream feeder for the K2-RED shift reducer (`k2red_ln_shift`).
- Pipelined LOG_Q x LOG_Q integer multiplier: produces the 2*LOG_Q-bit product `a_out` for the reducer's A input, with modulus and shift amounts (`q_out`, `l1_out..l3_out`) cycle-aligned.
- Tracks valid through its own pipeline and through the reducer's fixed latency, so downstream logic knows when the reducer's C2 is valid.
- Counts in-flight operations and flags out-of-range operands.

Parameters:
- LOG_Q, 64, operand/modulus width; must be even.
- LOG_L, 4, width of shift-amount fields l1/l2/l3.
- SPEED_OPT, 1, must equal the reducer's SPEED_OPT; sets reducer latency RED_LAT = 5 + 2*SPEED_OPT.
- MUL_LAT, 3, multiplier latency in cycles; fixed at 3, other values illegal.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand pair valid this cycle
- x  in  LOG_Q  multiplicand
- y  in  LOG_Q  multiplier
- q  in  LOG_Q  modulus for this operation
- l1, l2, l3  in  LOG_L each  Proth-shape shift amounts
- a_out  out  2*LOG_Q  product x*y, to reducer A
- q_out  out  LOG_Q  modulus aligned with a_out, to reducer Q
- l1_out, l2_out, l3_out  out  LOG_L each  shifts aligned with a_out
- a_valid  out  1  a_out/q_out valid this cycle
- c_valid  out  1  reducer C2 valid this cycle
- in_flight  out  clog2(MUL_LAT+RED_LAT+1)  operations accepted but not yet retired at c_valid
- busy  out  1  in_flight != 0
- range_err  out  1  sticky: an accepted operand satisfied x>=q or y>=q

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - clears the valid pipeline, a_valid, c_valid, in_flight, busy and range_err;
  - a_out, q_out and l*_out reset to 0;
  - reset mid-operation discards all in-flight work, including operations already inside the reducer;
  - c_valid stays 0 for RED_LAT cycles after reset release unless new inputs arrive.
- No backpressure. One operation may be accepted every cycle. Inputs are sampled only when in_valid=1; datapath registers hold their value when the valid bit is 0.
- Pipeline, with H = LOG_Q/2:
  - S1 registers x, y, q, l* and valid.
  - S2 registers the four H x H partial products: xh*yh, xh*yl, xl*yh, xl*yl.
  - S3 computes a_out = (hh<<LOG_Q) + ((hl+lh)<<H) + ll, full 2*LOG_Q width with no truncation. The middle sum is LOG_Q+1 bits.
- Latency: a_valid is asserted exactly MUL_LAT = 3 cycles after the accepting edge.
- c_valid is a_valid delayed by RED_LAT cycles (7 at default), so it is asserted MUL_LAT+RED_LAT = 10 cycles after acceptance.
- q_out is presented in the same cycle as a_out; the reducer samples A and Q together.
- in_flight:
  - +1 on an accept, -1 on c_valid; a simultaneous accept and c_valid leaves it unchanged.
  - Maximum value is MUL_LAT+RED_LAT; it cannot overflow because there is no backpressure.
  - Underflow is impossible by construction; a bench assertion checks this.
- range_err is set in S1 when a registered valid operand has x>=q or y>=q (unsigned compare). It clears only on reset. The product is still computed and passed through.
- q=0 with a valid input sets range_err (any x is >= 0).

Decomposition:
- Shared package `k2red_pkg`:
  - function `red_lat(speed_opt)` = 5 + 2*speed_opt;
  - constant MUL_LAT = 3;
  - in-flight width function.
- The reducer also uses `red_lat` from this package, so the two latencies cannot drift.
- One sub-module, `k2red_valid_delay` (parameter DEPTH): a resettable 1-bit shift register. It generates c_valid from a_valid and is reusable wherever the reducer latency must be tracked.

Test Plan:
- Smallest operands: reset, then x=3, y=5, q=17 with one valid pulse -> a_out=15, q_out=17, a_valid at cycle+3; c_valid at cycle+10; in_flight goes 1 then 0 after c_valid; range_err=0.
- Maximum operands: x=y=2^64-1, q=2^64-1 -> range_err=1 and a_out = 2^128 - 2^65 + 1. Then x=y=2^64-2 with the same q -> correct product, range_err remains 1.
- Back-to-back: 12 consecutive valids with x=i, y=i+1 -> a_out=i*(i+1) in order on 12 consecutive a_valid cycles; in_flight saturates at 10 with no overshoot while accepts and retires overlap.
- Bubbles: valid pattern 1,0,1,1,0 -> a_valid reproduces the pattern exactly 3 cycles later and c_valid 10 cycles later; a_out holds its value during bubbles.
- Mid-operation reset: issue 4 ops, assert rst_n=0 for 1 cycle at cycle 5 -> no a_valid/c_valid for the discarded ops, in_flight=0, range_err cleared, outputs 0.
- End-to-end with the reducer (LOG_Q=64, M=47, SPEED_OPT=1): random x, y < q -> C2 == (x*y) mod q whenever c_valid=1.

Source files
------------

// File: rtl/k2red_pkg.sv
// k2red_pkg: latency constants and width helpers shared by the K2-RED multiplier front end and shift reducer.
package k2red_pkg;

  localparam int MUL_LAT = 3;

  function automatic int red_lat(input int speed_opt);
    return 5 + 2 * speed_opt;
  endfunction

  // Holds 0..mul_lat+red_lat, the most operations that can be outstanding.
  function automatic int flight_w(input int mul_lat, input int speed_opt);
    return $clog2(mul_lat + red_lat(speed_opt) + 1);
  endfunction

endpackage

// File: rtl/k2red_valid_delay.sv
// k2red_valid_delay: resettable 1-bit shift register tracking a valid flag through a fixed latency.
module k2red_valid_delay #(
  parameter int DEPTH = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] sr;
  always_ff @(posedge clk)
    if (!rst_n) sr <= '0;
    else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/k2red_mul_front.sv
// k2red_mul_front: 3-stage split multiplier feeding the K2-RED reducer, with valid/latency tracking and operand range checks.
module k2red_mul_front
  import k2red_pkg::*;
#(
  parameter int LOG_Q     = 64,
  parameter int LOG_L     = 4,
  parameter int SPEED_OPT = 1,
  parameter int MUL_LAT   = k2red_pkg::MUL_LAT
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       in_valid,
  input  logic [LOG_Q-1:0]                           x,
  input  logic [LOG_Q-1:0]                           y,
  input  logic [LOG_Q-1:0]                           q,
  input  logic [LOG_L-1:0]                           l1,
  input  logic [LOG_L-1:0]                           l2,
  input  logic [LOG_L-1:0]                           l3,
  output logic [2*LOG_Q-1:0]                         a_out,
  output logic [LOG_Q-1:0]                           q_out,
  output logic [LOG_L-1:0]                           l1_out,
  output logic [LOG_L-1:0]                           l2_out,
  output logic [LOG_L-1:0]                           l3_out,
  output logic                                       a_valid,
  output logic                                       c_valid,
  output logic [flight_w(MUL_LAT, SPEED_OPT)-1:0]    in_flight,
  output logic                                       busy,
  output logic                                       range_err
);
  localparam int H       = LOG_Q / 2;
  localparam int RED_LAT = red_lat(SPEED_OPT);

  logic               s1_v, s2_v;
  logic [LOG_Q-1:0]   x1, y1, q1, q2;
  logic [3*LOG_L-1:0] s1_l, s2_l;
  logic [LOG_Q-1:0]   hh, hl, lh, ll;
  logic [LOG_Q:0]     mid;

  assign mid = (LOG_Q+1)'(hl) + (LOG_Q+1)'(lh);

  always_ff @(posedge clk)
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      a_valid   <= 1'b0;
      range_err <= 1'b0;
    end else begin
      s1_v      <= in_valid;
      s2_v      <= s1_v;
      a_valid   <= s2_v;
      range_err <= range_err | (s1_v & ((x1 >= q1) | (y1 >= q1)));
    end

  // Datapath stages only load behind a valid bit so outputs hold across bubbles.
  always_ff @(posedge clk)
    if (!rst_n) begin
      x1 <= '0;
      y1 <= '0;
      q1 <= '0;
      s1_l <= '0;
      hh <= '0;
      hl <= '0;
      lh <= '0;
      ll <= '0;
      q2 <= '0;
      s2_l <= '0;
      a_out <= '0;
      q_out <= '0;
      {l3_out, l2_out, l1_out} <= '0;
    end else begin
      if (in_valid) begin
        x1   <= x;
        y1   <= y;
        q1   <= q;
        s1_l <= {l3, l2, l1};
      end
      if (s1_v) begin
        hh   <= LOG_Q'(x1[LOG_Q-1:H]) * LOG_Q'(y1[LOG_Q-1:H]);
        hl   <= LOG_Q'(x1[LOG_Q-1:H]) * LOG_Q'(y1[H-1:0]);
        lh   <= LOG_Q'(x1[H-1:0]) * LOG_Q'(y1[LOG_Q-1:H]);
        ll   <= LOG_Q'(x1[H-1:0]) * LOG_Q'(y1[H-1:0]);
        q2   <= q1;
        s2_l <= s1_l;
      end
      if (s2_v) begin
        a_out <= {hh, ll} + {{(LOG_Q-H-1){1'b0}}, mid, {H{1'b0}}};
        q_out <= q2;
        {l3_out, l2_out, l1_out} <= s2_l;
      end
    end

  always_ff @(posedge clk)
    if (!rst_n) in_flight <= '0;
    else if (in_valid != c_valid) in_flight <= in_valid ? in_flight + 1'b1 : in_flight - 1'b1;

  assign busy = |in_flight;

  k2red_valid_delay #(.DEPTH(RED_LAT)) u_c_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (a_valid),
    .q     (c_valid)
  );
endmodule
